// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: owns the fetch PC, drives the imem req/ack handshake,
// applies branch/trap redirects and hands a stall-qualified PC to decode.
module fetch_pc_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] out_pc,
    output logic            out_valid,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] OffMask = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PcStep  = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] tgt_aligned;
    logic            tgt_misaligned;
    logic            redir;
    logic            slot_free;
    logic [XLEN-1:0] pc_inc;

    always_comb begin
        tgt            = trap_valid ? trap_pc : redirect_pc;
        redir          = trap_valid | redirect_valid;
        tgt_aligned    = tgt & ~OffMask;
        tgt_misaligned = |(tgt & OffMask);
        slot_free      = !out_valid_q || !stall;
        pc_inc         = pc_q + PcStep;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        kill_d      = kill_q;
        out_pc_d    = out_pc_q;
        // A held instruction survives only while decode is stalled.
        out_valid_d = out_valid_q & stall;
        misalign_d  = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StReq;
                addr_d  = pc_q;
            end

            StReq: begin
                if (redir) begin
                    pc_d        = tgt_aligned;
                    out_valid_d = 1'b0;
                    misalign_d  = tgt_misaligned;
                    if (imem_ack) begin
                        addr_d = tgt_aligned;
                        kill_d = 1'b0;
                    end else begin
                        // Request already on the bus must complete unchanged; drop its response.
                        kill_d = 1'b1;
                    end
                end else if (imem_ack && kill_q) begin
                    kill_d = 1'b0;
                    addr_d = pc_q;
                end else if (imem_ack && slot_free) begin
                    out_pc_d    = addr_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_inc;
                    addr_d      = pc_inc;
                end else if (imem_ack) begin
                    state_d     = StHold;
                    out_valid_d = out_valid_q;
                end
            end

            StHold: begin
                if (redir) begin
                    pc_d        = tgt_aligned;
                    addr_d      = tgt_aligned;
                    out_valid_d = 1'b0;
                    misalign_d  = tgt_misaligned;
                    state_d     = StReq;
                end else if (slot_free) begin
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_inc;
                    addr_d      = pc_inc;
                    state_d     = StReq;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            pc_q        <= RESET_VECTOR;
            addr_q      <= RESET_VECTOR;
            kill_q      <= 1'b0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign imem_req     = (state_q == StReq);
    assign imem_addr    = addr_q;
    assign out_pc       = out_pc_q;
    assign out_valid    = out_valid_q;
    assign misalign_err = misalign_q;

`ifndef SYNTHESIS
    addr_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
        imem_req && !imem_ack |=> $stable(imem_addr));
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_pc_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RV   = 64'h0;
    localparam logic [63:0] IB   = 64'd4;

    localparam int PhBoot   = 0;
    localparam int PhFetch  = 1;
    localparam int PhParked = 2;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        stall          = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;
    logic        trap_valid     = 1'b0;
    logic [63:0] trap_pc        = '0;
    logic        imem_ack       = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [63:0] out_pc;
    logic        out_valid;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Model: what fetch is doing, where the next instruction comes from, what decode sees.
    int          m_phase;
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    logic        m_drop;
    logic [63:0] m_opc;
    logic        m_ov;
    logic        m_mis;

    fetch_pc_unit #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV),
        .INSTR_BYTES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .out_pc        (out_pc),
        .out_valid     (out_valid),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PhBoot;
        m_pc    = RV;
        m_addr  = RV;
        m_drop  = 1'b0;
        m_opc   = '0;
        m_ov    = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One clock of the fetch rules, using the inputs presented for this edge.
    task automatic model_step();
        logic [63:0] target;
        logic        jump;
        logic        room;
        logic        keep;
        target = trap_valid ? trap_pc : redirect_pc;
        jump   = trap_valid || redirect_valid;
        room   = !m_ov || !stall;
        keep   = m_ov && stall;
        m_mis  = 1'b0;
        if (m_phase == PhBoot) begin
            m_phase = PhFetch;
            m_addr  = m_pc;
            m_ov    = keep;
        end else if (jump) begin
            m_mis = (target % IB) != 0;
            m_pc  = target - (target % IB);
            m_ov  = 1'b0;
            if (m_phase == PhParked || imem_ack) begin
                m_addr = m_pc;
                m_drop = 1'b0;
            end else begin
                m_drop = 1'b1;
            end
            m_phase = PhFetch;
        end else if (m_phase == PhParked) begin
            if (room) begin
                m_opc   = m_pc;
                m_ov    = 1'b1;
                m_pc    = m_pc + IB;
                m_addr  = m_pc;
                m_phase = PhFetch;
            end
        end else if (imem_ack && m_drop) begin
            m_drop = 1'b0;
            m_addr = m_pc;
            m_ov   = keep;
        end else if (imem_ack && room) begin
            m_opc  = m_addr;
            m_ov   = 1'b1;
            m_pc   = m_addr + IB;
            m_addr = m_pc;
        end else if (imem_ack) begin
            m_phase = PhParked;
        end else begin
            m_ov = keep;
        end
    endtask

    task automatic compare_all();
        check_bit("imem_req", imem_req, m_phase == PhFetch);
        if (m_phase == PhFetch) check_word("imem_addr", imem_addr, m_addr);
        check_bit("out_valid", out_valid, m_ov);
        if (m_ov) check_word("out_pc", out_pc, m_opc);
        check_bit("misalign_err", misalign_err, m_mis);
    endtask

    task automatic cyc(input logic st, input logic rv, input logic [63:0] rpc,
                       input logic tv, input logic [63:0] tpc, input logic ack);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_pc        = tpc;
        imem_ack       = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_bit("async rst imem_req", imem_req, 1'b0);
        check_bit("async rst out_valid", out_valid, 1'b0);
        check_bit("async rst misalign_err", misalign_err, 1'b0);
        check_word("async rst imem_addr", imem_addr, RV);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    function automatic logic [63:0] rand_tgt();
        logic [63:0] t;
        case ($urandom_range(0, 2))
            0:       t = 64'($urandom_range(0, 1023));
            1:       t = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            default: t = {$urandom(), $urandom()};
        endcase
        return t;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset imem_req", imem_req, 1'b0);
        check_word("reset imem_addr", imem_addr, 64'h0);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_word("reset out_pc", out_pc, 64'h0);
        check_bit("reset misalign_err", misalign_err, 1'b0);
        rst_n = 1'b1;
        compare_all();

        // Sequential fetch, ack every cycle
        cyc(0, 0, 0, 0, 0, 1);
        check_bit("boot req", imem_req, 1'b1);
        check_word("seq addr0", imem_addr, 64'h0);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("seq addr4", imem_addr, 64'h4);
        check_word("seq out0", out_pc, 64'h0);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("seq addr8", imem_addr, 64'h8);
        check_word("seq out4", out_pc, 64'h4);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("seq addr12", imem_addr, 64'hC);
        check_word("seq out8", out_pc, 64'h8);

        // Stall with a response arriving parks the fetch
        cyc(1, 0, 0, 0, 0, 1);
        check_bit("hold req", imem_req, 1'b0);
        check_word("hold out_pc", out_pc, 64'h8);
        cyc(1, 0, 0, 0, 0, 0);
        check_bit("hold2 out_valid", out_valid, 1'b1);
        cyc(0, 0, 0, 0, 0, 0);
        check_word("resume out_pc", out_pc, 64'hC);
        check_word("resume addr", imem_addr, 64'h10);

        // Redirect with a request outstanding
        cyc(0, 1, 64'h100, 0, 0, 0);
        check_word("redir addr held", imem_addr, 64'h10);
        check_bit("redir out_valid", out_valid, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check_bit("killed resp", out_valid, 1'b0);
        check_word("redir new addr", imem_addr, 64'h100);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("redir out_pc", out_pc, 64'h100);

        // Trap beats redirect
        cyc(0, 1, 64'h200, 1, 64'h80, 1);
        check_word("trap addr", imem_addr, 64'h80);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("trap out_pc", out_pc, 64'h80);

        // Misaligned target
        cyc(0, 1, 64'h102, 0, 0, 1);
        check_bit("misalign pulse", misalign_err, 1'b1);
        check_word("misalign addr", imem_addr, 64'h100);
        cyc(0, 0, 0, 0, 0, 0);
        check_bit("misalign single", misalign_err, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);

        // Wrap at top of address space
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check_word("wrap out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_word("wrap addr", imem_addr, 64'h0);

        // Reset mid-handshake
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        check_word("reboot addr", imem_addr, RV);
        check_bit("reboot req", imem_req, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) == 0, rand_tgt(),
                    $urandom_range(0, 19) == 0, rand_tgt(),
                    $urandom_range(0, 9) < 6);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
